// File: rtl/dlfloat16_pkg.sv
// Shared constants for the DLfloat16 output stage.
//   DLF_*         : packed-format constants (NaN pattern, max exponent,
//                   largest finite mantissa at the max exponent)
//   RNE..RDN      : rounding-mode encodings
//   EXC_*         : bit positions in the 5-bit exception vector
//                   {invalid, inexact, overflow, underflow, div_zero}
//   dlf_ext_t     : 20-bit extended result coming from the add/sub unit
package dlfloat16_pkg;

    localparam logic [15:0] DLF_NAN          = 16'hFFFF;
    localparam logic [5:0]  DLF_EXP_MAX      = 6'd63;
    localparam logic [8:0]  DLF_MANT_MAX_FIN = 9'h1FE;

    localparam logic [1:0] RNE = 2'b00;  // nearest, ties to even
    localparam logic [1:0] RTZ = 2'b01;  // toward zero
    localparam logic [1:0] RUP = 2'b10;  // toward +inf
    localparam logic [1:0] RDN = 2'b11;  // toward -inf

    localparam int EXC_INV = 4;
    localparam int EXC_INX = 3;
    localparam int EXC_OVF = 2;
    localparam int EXC_UNF = 1;
    localparam int EXC_DZ  = 0;

    // m[12:4] survive into the packed word, m[3:0] are guard/round/sticky
    typedef struct packed {
        logic        s;
        logic [5:0]  e;
        logic [12:0] m;
    } dlf_ext_t;

endpackage

// File: rtl/dlfloat16_round_pack_if.sv
// Handshake bundle for dlfloat16_round_pack.
//   Input side : in_valid/in_ready, in_data (20b extended), in_exc, rounding
//                control (rnd_override, rnd_mode)
//   Output side: out_valid/out_ready, out_data (16b packed), out_exc
//   Flags      : flag_clr in, sticky_flags out
// master = producer/consumer environment, slave = the rounding block.
interface dlfloat16_round_pack_if;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic [4:0]  in_exc;
    logic        rnd_override;
    logic [1:0]  rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [4:0]  out_exc;
    logic        flag_clr;
    logic [4:0]  sticky_flags;

    modport master (
        output in_valid, in_data, in_exc, rnd_override, rnd_mode, out_ready, flag_clr,
        input  in_ready, out_valid, out_data, out_exc, sticky_flags
    );

    modport slave (
        input  in_valid, in_data, in_exc, rnd_override, rnd_mode, out_ready, flag_clr,
        output in_ready, out_valid, out_data, out_exc, sticky_flags
    );
endinterface

// File: rtl/dlfloat16_round_decide.sv
// Combinational rounding decision.
//   s, lsb, guard, rnd, sticky : sign, kept LSB and the three dropped-bit terms
//   mode                       : rounding mode (RNE/RTZ/RUP/RDN)
//   round_up                   : increment the kept magnitude
//   inexact                    : any dropped bit was set
module dlfloat16_round_decide
    import dlfloat16_pkg::*;
(
    input  logic       s,
    input  logic       lsb,
    input  logic       guard,
    input  logic       rnd,
    input  logic       sticky,
    input  logic [1:0] mode,
    output logic       round_up,
    output logic       inexact
);
    always_comb begin
        inexact  = guard | rnd | sticky;
        round_up = 1'b0;
        case (mode)
            RNE:     round_up = guard & (lsb | rnd | sticky);
            RTZ:     round_up = 1'b0;
            RUP:     round_up = !s & inexact;
            RDN:     round_up = s & inexact;
            default: round_up = 1'b0;
        endcase
    end
endmodule

// File: rtl/dlfloat16_round_pack.sv
// Rounding/packing stage after the DLfloat16 add/sub unit.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of dlfloat16_round_pack_if
// Two stages: S1 captures the extended result and effective rounding mode and
// forms the round-up decision; S2 applies increment/saturation/specials and
// holds the registered output until the downstream handshake.
module dlfloat16_round_pack
    import dlfloat16_pkg::*;
#(
    parameter logic [1:0] RND_DEFAULT = RNE
) (
    input  logic                 clk,
    input  logic                 rst,
    dlfloat16_round_pack_if.slave bus
);
    logic        s1_valid;
    dlf_ext_t    s1_in;
    logic [4:0]  s1_exc;
    logic [1:0]  s1_mode;
    logic        round_up;
    logic        grs;

    logic        out_valid_q;
    logic [15:0] out_data_q;
    logic [4:0]  out_exc_q;
    logic [4:0]  sticky_q;

    logic        s2_adv;
    logic        out_hs;
    logic [15:0] sum;
    logic        nan;
    logic        zero;
    logic        ovf;
    logic [4:0]  exc_own;
    logic [15:0] data_nxt;
    logic [4:0]  exc_nxt;

    // S2 can take a new entry whenever it is empty or draining this cycle
    assign s2_adv       = !out_valid_q | bus.out_ready;
    assign bus.in_ready = !s1_valid | s2_adv;
    assign out_hs       = out_valid_q & bus.out_ready;

    assign bus.out_valid    = out_valid_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_exc      = out_exc_q;
    assign bus.sticky_flags = sticky_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_in   <= bus.in_data;
                s1_exc  <= bus.in_exc;
                s1_mode <= bus.rnd_override ? bus.rnd_mode : RND_DEFAULT;
            end
        end
    end

    dlfloat16_round_decide u_decide (
        .s        (s1_in.s),
        .lsb      (s1_in.m[4]),
        .guard    (s1_in.m[3]),
        .rnd      (s1_in.m[2]),
        .sticky   (|s1_in.m[1:0]),
        .mode     (s1_mode),
        .round_up (round_up),
        .inexact  (grs)
    );

    always_comb begin
        nan  = (s1_in.e == DLF_EXP_MAX) && (s1_in.m[12:4] == 9'h1FF);
        zero = (s1_in.e == 6'd0);
        // exponent and mantissa incremented together so a mantissa carry
        // bumps the exponent; bit 15 catches a carry past e=63
        sum  = {1'b0, s1_in.e, s1_in.m[12:4]} + {15'b0, round_up};
        ovf  = !nan && !zero && (sum[15] || (sum[14:0] == {DLF_EXP_MAX, 9'h1FF}));

        exc_own          = 5'b0;
        exc_own[EXC_INV] = nan;
        // zero/subnormal flushes the whole mantissa, kept bits included
        exc_own[EXC_INX] = zero ? (|s1_in.m) : (grs & !nan);
        exc_own[EXC_OVF] = ovf;
        exc_own[EXC_UNF] = 1'b0;
        exc_own[EXC_DZ]  = 1'b0;

        if (nan)       data_nxt = DLF_NAN;
        else if (zero) data_nxt = {s1_in.s, 15'b0};
        else if (ovf)  data_nxt = {s1_in.s, DLF_EXP_MAX, DLF_MANT_MAX_FIN};
        else           data_nxt = {s1_in.s, sum[14:0]};

        exc_nxt = s1_exc | exc_own;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 16'h0000;
            out_exc_q   <= 5'b0;
            sticky_q    <= 5'b0;
        end else begin
            if (s2_adv) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    out_data_q <= data_nxt;
                    out_exc_q  <= exc_nxt;
                end
            end
            // a clear wipes only what was accumulated before this cycle
            if (bus.flag_clr)
                sticky_q <= out_hs ? out_exc_q : 5'b0;
            else if (out_hs)
                sticky_q <= sticky_q | out_exc_q;
        end
    end
endmodule

// File: tb/tb_dlfloat16_round_pack.sv
module tb_dlfloat16_round_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    dlfloat16_round_pack_if bus();

    dlfloat16_round_pack #(.RND_DEFAULT(2'b00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: treat {e, m[12:4]} as an unsigned magnitude k and m[3:0] as
    // a residue r in sixteenths of an ulp; round k by comparing r to half.
    function automatic logic [20:0] model(input logic [19:0] d, input logic [4:0] x,
                                          input logic [1:0] md);
        int k, r, n;
        logic s, up, inx, ovf, nan;
        logic [15:0] o;
        s   = d[19];
        k   = {17'b0, d[18:4]};
        r   = {28'b0, d[3:0]};
        nan = (k == 32'h7FFF);
        up  = 1'b0;
        case (md)
            2'd0: up = (r > 8) || (r == 8 && (k % 2) == 1);
            2'd1: up = 1'b0;
            2'd2: up = !s && r != 0;
            2'd3: up = s && r != 0;
            default: up = 1'b0;
        endcase
        n   = k + (up ? 1 : 0);
        inx = 1'b0;
        ovf = 1'b0;
        if (nan) o = 16'hFFFF;
        else if (d[18:13] == 6'd0) begin
            o   = {s, 15'b0};
            inx = (d[12:0] != 13'd0);
        end else if (n >= 32'h7FFF) begin
            o   = {s, 15'h7FFE};
            ovf = 1'b1;
            inx = 1'b1;
        end else begin
            o   = {s, n[14:0]};
            inx = (r != 0);
        end
        return {o, x | {nan, inx, ovf, 2'b00}};
    endfunction

    task automatic idle();
        bus.in_valid     = 1'b0;
        bus.in_data      = 20'h0;
        bus.in_exc       = 5'b0;
        bus.rnd_override = 1'b0;
        bus.rnd_mode     = 2'b00;
        bus.out_ready    = 1'b1;
        bus.flag_clr     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One isolated transaction with out_ready=1; checks 2-cycle latency and result
    task automatic send_one(input logic [19:0] d, input logic [4:0] x, input logic ovr,
                            input logic [1:0] md, input string nm);
        logic [20:0] e;
        e = model(d, x, ovr ? md : 2'b00);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = d; bus.in_exc = x;
        bus.rnd_override = ovr; bus.rnd_mode = md; bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++; $display("FAIL %s in_ready: got %b want 1", nm, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rnd_mode = ~md;   // later mode changes must not touch this one
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++; $display("FAIL %s latency1: out_valid %b want 0", nm, bus.out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_exc} !== e) begin
            fails++;
            $display("FAIL %s result: valid %b data %h exc %b want data %h exc %b",
                     nm, bus.out_valid, bus.out_data, bus.out_exc, e[20:5], e[4:0]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 || bus.out_exc !== 5'b0 ||
            bus.sticky_flags !== 5'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: valid %b data %h exc %b sticky %b in_ready %b want 0 0000 0 0 1",
                     bus.out_valid, bus.out_data, bus.out_exc, bus.sticky_flags, bus.in_ready);
        end
    endtask

    task automatic test_rne();
        send_one({1'b0, 6'h20, 13'h1008}, 5'b0, 1'b0, 2'b00, "rne_tie_even");
        checks++;
        if (bus.out_data !== 16'h4100 || bus.out_exc !== 5'b01000) begin
            fails++; $display("FAIL rne_const: got %h/%b want 4100/01000", bus.out_data, bus.out_exc);
        end
        send_one({1'b0, 6'h20, 13'h1018}, 5'b0, 1'b0, 2'b00, "rne_tie_odd");
        send_one({1'b0, 6'h20, 13'h1FFF}, 5'b0, 1'b0, 2'b00, "rne_carry");
        checks++;
        if (bus.out_data !== 16'h4200) begin
            fails++; $display("FAIL carry_const: got %h want 4200", bus.out_data);
        end
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++)
            send_one({1'b1, 6'h20, 13'h1001}, 5'b0, 1'b1, 2'(m), "mode_neg");
        checks++;
        if (bus.out_data !== 16'hC101) begin
            fails++; $display("FAIL rdn_const: got %h want c101", bus.out_data);
        end
        // override off: mode input ignored, default RNE used
        send_one({1'b1, 6'h20, 13'h1001}, 5'b0, 1'b0, 2'b11, "mode_default");
        send_one({1'b0, 6'h00, 13'h0123}, 5'b00010, 1'b0, 2'b00, "subnormal");
    endtask

    task automatic test_saturation();
        send_one({1'b0, 6'h3F, 13'h1FEC}, 5'b0, 1'b0, 2'b00, "saturate");
        checks++;
        if (bus.out_data !== 16'h7FFE || bus.out_exc !== 5'b01100) begin
            fails++; $display("FAIL sat_const: got %h/%b want 7ffe/01100", bus.out_data, bus.out_exc);
        end
        send_one({1'b1, 6'h3F, 13'h1FF0}, 5'b00001, 1'b1, 2'b10, "nan");
        checks++;
        if (bus.out_data !== 16'hFFFF || bus.out_exc !== 5'b10001) begin
            fails++; $display("FAIL nan_const: got %h/%b want ffff/10001", bus.out_data, bus.out_exc);
        end
    endtask

    // Streaming with scoreboard; ready pattern 1,0,0,1 or random
    task automatic run_stream(input int n, input bit rnd, input string nm);
        logic [20:0] exp_q[$];
        logic [20:0] e, held;
        logic [19:0] d;
        logic [4:0]  x, sticky_m;
        logic        ov, stalled;
        logic [1:0]  md;
        int sent, recv, cyc, inflight, sel;
        sent = 0; recv = 0; cyc = 0; stalled = 1'b0; held = '0; sticky_m = 5'b0;
        d = '0; x = '0; ov = 1'b0; md = 2'b00;
        do_reset();
        while (recv < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : ((cyc % 4) <= 1);
            if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
                d   = 20'($urandom);
                sel = $urandom_range(0, 9);
                if (sel == 0) d[18:13] = 6'd0;
                else if (sel == 1) begin
                    d[18:13] = 6'h3F;
                    if ($urandom_range(0, 1) == 1) d[12:4] = 9'h1FF;
                end
                x  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
                ov = 1'($urandom);
                md = 2'($urandom);
                bus.in_valid = 1'b1; bus.in_data = d; bus.in_exc = x;
                bus.rnd_override = ov; bus.rnd_mode = md;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            inflight = sent - recv;
            checks++;
            if (bus.in_ready !== (inflight < 2 || bus.out_ready)) begin
                fails++;
                $display("FAIL %s in_ready: got %b inflight %0d out_ready %b", nm, bus.in_ready,
                         inflight, bus.out_ready);
            end
            if (stalled) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.out_data, bus.out_exc} !== held) begin
                    fails++;
                    $display("FAIL %s hold: valid %b data %h want %h", nm, bus.out_valid,
                             bus.out_data, held[20:5]);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL %s extra output: data %h want none", nm, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    sticky_m |= e[4:0];
                    if ({bus.out_data, bus.out_exc} !== e) begin
                        fails++;
                        $display("FAIL %s data: got %h/%b want %h/%b", nm, bus.out_data,
                                 bus.out_exc, e[20:5], e[4:0]);
                    end
                end
                recv++;
            end
            stalled = (bus.out_valid === 1'b1) && !bus.out_ready;
            held    = {bus.out_data, bus.out_exc};
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back(model(d, x, ov ? md : 2'b00));
                sent++;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (recv < n) begin
            fails++; $display("FAIL %s timeout: received %0d want %0d", nm, recv, n);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.sticky_flags !== sticky_m) begin
            fails++; $display("FAIL %s sticky: got %b want %b", nm, bus.sticky_flags, sticky_m);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(4, 1'b0, "backpressure");
        run_stream(200, 1'b1, "random");
    endtask

    task automatic test_flags();
        do_reset();
        send_one({1'b0, 6'h3F, 13'h1FEC}, 5'b0, 1'b0, 2'b00, "flag_ovf");
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = {1'b0, 6'h20, 13'h1008}; bus.in_exc = 5'b0;
        bus.rnd_override = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.sticky_flags !== 5'b01100) begin
            fails++; $display("FAIL sticky_accum: got %b want 01100", bus.sticky_flags);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b1; bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        #1;
        checks++;
        if (bus.sticky_flags !== 5'b01000) begin
            fails++; $display("FAIL sticky_clr_hs: got %b want 01000", bus.sticky_flags);
        end
        bus.flag_clr = 1'b1;
        @(negedge clk);
        bus.flag_clr = 1'b0;
        #1;
        checks++;
        if (bus.sticky_flags !== 5'b00000) begin
            fails++; $display("FAIL sticky_clr: got %b want 00000", bus.sticky_flags);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        send_one({1'b0, 6'h3F, 13'h1FEC}, 5'b0, 1'b0, 2'b00, "pre_rst");
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = {1'b0, 6'h10, 13'h0005};
        @(negedge clk);
        bus.in_data = {1'b1, 6'h11, 13'h0009};
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sticky_flags !== 5'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid: valid %b sticky %b in_ready %b want 0 00000 1",
                     bus.out_valid, bus.sticky_flags, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            fails++; $display("FAIL reset_flush: out_valid seen 1 want 0");
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_rne();
        test_modes();
        test_saturation();
        test_back_to_back();
        test_flags();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
